// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus of the register file: two write requesters, the registered write
// port, and the two read ports with their raw and bypassed data.
interface regfile_wb_arbiter_if #(
  parameter int WORDSIZE  = 64,
  parameter int ADDRWIDTH = 5
);
  logic                 req0_valid;
  logic [ADDRWIDTH-1:0] req0_addr;
  logic [WORDSIZE-1:0]  req0_data;
  logic                 req0_ready;

  logic                 req1_valid;
  logic [ADDRWIDTH-1:0] req1_addr;
  logic [WORDSIZE-1:0]  req1_data;
  logic                 req1_ready;

  logic                 write_en;
  logic [ADDRWIDTH-1:0] write_addr;
  logic [WORDSIZE-1:0]  write_data;

  logic [ADDRWIDTH-1:0] addr_a;
  logic [ADDRWIDTH-1:0] addr_b;
  logic [WORDSIZE-1:0]  rf_data_a;
  logic [WORDSIZE-1:0]  rf_data_b;
  logic [WORDSIZE-1:0]  data_a;
  logic [WORDSIZE-1:0]  data_b;

  // The master side is the environment: requesters, consumers and the register file.
  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  write_en, write_addr, write_data,
    output addr_a, addr_b, rf_data_a, rf_data_b,
    input  data_a, data_b
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output write_en, write_addr, write_data,
    input  addr_a, addr_b, rf_data_a, rf_data_b,
    output data_a, data_b
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write port, with
// read bypass of the write that is registered but not yet committed.
module regfile_wb_arbiter #(
  parameter int WORDSIZE  = 64,
  parameter int ADDRWIDTH = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);
  logic                 last_grant;
  logic                 grant0;
  logic                 grant1;
  logic                 transfer;
  logic [ADDRWIDTH-1:0] grant_addr;
  logic [WORDSIZE-1:0]  grant_data;
  logic                 write_en_q;
  logic [ADDRWIDTH-1:0] write_addr_q;
  logic [WORDSIZE-1:0]  write_data_q;

  // On contention the requester that did not win last time goes first; ready never sees addr/data.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign transfer       = grant0 || grant1;
  assign grant_addr     = grant1 ? bus.req1_addr : bus.req0_addr;
  assign grant_data     = grant1 ? bus.req1_data : bus.req0_data;
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Writes to register 0 are accepted but never enabled toward the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant   <= 1'b1;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      write_en_q <= transfer && (grant_addr != '0);
      if (transfer) begin
        last_grant   <= grant1;
        write_addr_q <= grant_addr;
        write_data_q <= grant_data;
      end
    end
  end

  assign bus.write_en   = write_en_q;
  assign bus.write_addr = write_addr_q;
  assign bus.write_data = write_data_q;

  always_comb begin
    bus.data_a = bus.rf_data_a;
    if (bus.addr_a == '0) begin
      bus.data_a = '0;
    end else if (write_en_q && (write_addr_q == bus.addr_a)) begin
      bus.data_a = write_data_q;
    end
  end

  always_comb begin
    bus.data_b = bus.rf_data_b;
    if (bus.addr_b == '0) begin
      bus.data_b = '0;
    end else if (write_en_q && (write_addr_q == bus.addr_b)) begin
      bus.data_b = write_data_q;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios then random traffic, checked against
// a transaction-level model of requests, pending write and register contents.
module tb_regfile_wb_arbiter;
  localparam int WS = 64;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.WORDSIZE(WS), .ADDRWIDTH(AW)) bus ();

  regfile_wb_arbiter #(.WORDSIZE(WS), .ADDRWIDTH(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int error_count = 0;
  int check_count = 0;

  // Model: the committed register contents, each requester's outstanding request,
  // the one write waiting to commit, and which requester wins the next tie.
  logic [WS-1:0] rf [32];
  bit            p_valid [2];
  logic [AW-1:0] p_addr [2];
  logic [WS-1:0] p_data [2];
  bit            m_we;
  logic [AW-1:0] m_wa;
  logic [WS-1:0] m_wd;
  int            m_pref;
  int            cur_grant;

  task automatic checkOutput(input string tag, input logic [WS-1:0] got, input logic [WS-1:0] want);
    check_count++;
    if (got !== want) begin
      error_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  function automatic logic [WS-1:0] expected_read(input logic [AW-1:0] a, input logic [WS-1:0] raw);
    if (a == '0) return '0;
    if (m_we && m_wa == a) return m_wd;
    return raw;
  endfunction

  task automatic applyStimulus(input bit v0, input logic [AW-1:0] a0, input logic [WS-1:0] d0,
                               input bit v1, input logic [AW-1:0] a1, input logic [WS-1:0] d1,
                               input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                               input logic [WS-1:0] junk);
    if (!p_valid[0] && v0) begin
      p_valid[0] = 1'b1; p_addr[0] = a0; p_data[0] = d0;
    end
    if (!p_valid[1] && v1) begin
      p_valid[1] = 1'b1; p_addr[1] = a1; p_data[1] = d1;
    end
    bus.req0_valid = p_valid[0];
    bus.req0_addr  = p_valid[0] ? p_addr[0] : a0;
    bus.req0_data  = p_valid[0] ? p_data[0] : d0;
    bus.req1_valid = p_valid[1];
    bus.req1_addr  = p_valid[1] ? p_addr[1] : a1;
    bus.req1_data  = p_valid[1] ? p_data[1] : d1;
    bus.addr_a     = ra;
    bus.addr_b     = rb;
    bus.rf_data_a  = (ra == '0) ? ~junk : rf[ra];
    bus.rf_data_b  = (rb == '0) ? junk : rf[rb];
  endtask

  task automatic check_cycle();
    if (!rst_n) begin
      m_we = 1'b0; m_wa = '0; m_wd = '0; m_pref = 0;
    end
    cur_grant = -1;
    if (rst_n) begin
      if (p_valid[0] && p_valid[1]) cur_grant = m_pref;
      else if (p_valid[0])          cur_grant = 0;
      else if (p_valid[1])          cur_grant = 1;
    end
    checkOutput("req0_ready", 64'(bus.req0_ready), 64'(cur_grant == 0));
    checkOutput("req1_ready", 64'(bus.req1_ready), 64'(cur_grant == 1));
    checkOutput("write_en",   64'(bus.write_en),   64'(m_we));
    checkOutput("write_addr", 64'(bus.write_addr), 64'(m_wa));
    checkOutput("write_data", bus.write_data, m_wd);
    checkOutput("data_a", bus.data_a, expected_read(bus.addr_a, bus.rf_data_a));
    checkOutput("data_b", bus.data_b, expected_read(bus.addr_b, bus.rf_data_b));
  endtask

  // At the edge the pending write commits to the register file and the winner becomes pending.
  task automatic model_edge();
    if (rst_n) begin
      if (m_we) rf[m_wa] = m_wd;
      if (cur_grant >= 0) begin
        m_we = (p_addr[cur_grant] != '0);
        m_wa = p_addr[cur_grant];
        m_wd = p_data[cur_grant];
        p_valid[cur_grant] = 1'b0;
        m_pref = 1 - cur_grant;
      end else begin
        m_we = 1'b0;
      end
    end
  endtask

  task automatic run_cycle(input bit rst_val, input bit mid_reset,
                           input bit v0, input logic [AW-1:0] a0, input logic [WS-1:0] d0,
                           input bit v1, input logic [AW-1:0] a1, input logic [WS-1:0] d1,
                           input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                           input logic [WS-1:0] junk);
    @(negedge clk);
    rst_n = rst_val;
    applyStimulus(v0, a0, d0, v1, a1, d1, ra, rb, junk);
    #2 check_cycle();
    if (mid_reset) begin
      #1 rst_n = 1'b0;
      #1 check_cycle();
    end
    @(posedge clk);
    model_edge();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
    rf[13] = '0;
    rf[4]  = '0;
    p_valid[0] = 1'b0; p_valid[1] = 1'b0;
    m_we = 1'b0; m_wa = '0; m_wd = '0; m_pref = 0; cur_grant = -1;
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.addr_a = '0; bus.addr_b = '0; bus.rf_data_a = '0; bus.rf_data_b = '0;

    // Both requests raised while still in reset; readies stay low until release.
    run_cycle(1'b0, 1'b0, 1'b1, 5'd13, 64'h0000_0000_0000_aabb,
              1'b1, 5'd4, 64'h0000_0000_e45f_b21f, 5'd13, 5'd0, 64'h1234);
    run_cycle(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd13, 5'd0, 64'h1234);
    run_cycle(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd13, 5'd4, 64'h1234);
    run_cycle(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd4, 5'd13, 64'h1234);
    run_cycle(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd0, 64'hffff, 5'd4, 5'd0, 64'h1234);
    run_cycle(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd4, 5'd0, 64'h1234);

    for (int n = 0; n < 6; n++) begin
      run_cycle(1'b1, 1'b0, 1'b1, AW'($urandom_range(1, 7)), {$urandom, $urandom},
                1'b1, AW'($urandom_range(1, 7)), {$urandom, $urandom},
                AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), {$urandom, $urandom});
    end

    // Reset pulled while a write is pending, then contention right after release.
    run_cycle(1'b1, 1'b0, 1'b1, 5'd9, {$urandom, $urandom}, 1'b0, 5'd0, '0, 5'd9, 5'd2, 64'h55);
    run_cycle(1'b1, 1'b1, 1'b1, 5'd2, {$urandom, $urandom}, 1'b1, 5'd3, {$urandom, $urandom},
              5'd9, 5'd9, 64'h66);
    run_cycle(1'b1, 1'b0, 1'b1, 5'd2, '0, 1'b1, 5'd3, '0, 5'd2, 5'd3, 64'h77);
    run_cycle(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd2, 5'd3, 64'h88);

    for (int n = 0; n < 300; n++) begin
      run_cycle(1'b1, ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 3) != 0), rand_addr(), {$urandom, $urandom},
                ($urandom_range(0, 3) != 0), rand_addr(), {$urandom, $urandom},
                rand_addr(), rand_addr(), {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and read-bypass unit for the 32 x WORDSIZE register file. It shares the register file's single write port between two write-back requesters, requester 0 (ALU) and requester 1 (load unit), using round-robin arbitration and a valid/ready handshake. Each granted write is registered into the register file's write port. Both read ports are forwarded so consumers always see the value of a write that has been granted but not yet committed.

## Interface
- WORDSIZE, 64, data width of every register and data port.
- ADDRWIDTH, 5, register address width (32 registers; register 0 is hardwired to zero).
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  ADDRWIDTH  requester 0 destination register.
- req0_data  in  WORDSIZE  requester 0 write value.
- req0_ready  out  1  requester 0 write accepted this cycle (combinational).
- req1_valid, req1_addr, req1_data, req1_ready  same as requester 0, for requester 1.
- write_en  out  1  register file write enable (registered).
- write_addr  out  ADDRWIDTH  register file write address (registered).
- write_data  out  WORDSIZE  register file write data (registered).
- addr_a, addr_b  in  ADDRWIDTH  consumer read addresses; also driven to the register file read ports.
- rf_data_a, rf_data_b  in  WORDSIZE  raw register file read data.
- data_a, data_b  out  WORDSIZE  bypassed read data presented to consumers.

## Operation
- **Handshake.** A transfer happens on a rising edge where reqN_valid && reqN_ready.
  - A requester holds addr and data stable while valid is high and unaccepted.
  - A requester may drop valid only after acceptance.
- **Arbitration.** The register file accepts one write per cycle, so at most one ready is high per cycle.
  - Only one requester valid: it is granted; its ready is high in the same cycle.
  - Both valid: grant goes to the requester not recorded in last_grant.
  - Neither valid: both readies are low.
- **last_grant.** A 1-bit register updated to the granted index on every transfer.
  - Reset value 1, so requester 0 wins the first contention.
  - Unchanged in cycles with no transfer.
- **Write stage.** On each rising edge:
  - write_addr <= granted address, write_data <= granted data.
  - write_en <= transfer && (granted address != 0).
  - A write to register 0 is accepted (ready high) but never reaches the register file.
  - With no transfer, write_en <= 0; addr and data hold their previous values.
- **Bypass.** Evaluated combinationally and independently for port a and port b:
  - addr_x == 0: data_x = 0.
  - Else write_en && write_addr == addr_x: data_x = write_data.
  - Else: data_x = rf_data_x.
- **Starvation.** Neither requester waits more than one cycle while continuously valid.

## Timing
- **Reset values:** write_en = 0, write_addr = 0, write_data = 0, last_grant = 1. While rst_n is low, req0_ready and req1_ready are forced to 0.
- **Reset mid-operation:**
  - Asserting rst_n clears the write stage immediately; a pending, uncommitted write is lost.
  - A request that was not accepted stays with its requester.
  - The first edge after rst_n deasserts may accept a request.
- **Latency:**
  - Edge k: request accepted.
  - Cycle k..k+1: write_en high.
  - Edge k+1: the register file captures the value.
  - From edge k onward: data_a and data_b reflect the value, through the bypass in cycle k..k+1 and from the register file after edge k+1.
- **Throughput:** one write per cycle, sustained. Back-to-back transfers to the same address leave the newest value in the write stage.
- **Simultaneous requests to the same address:** both complete in round-robin order, one cycle apart; the later-granted value persists.
- **Ready:** depends only on the valid inputs, last_grant and rst_n. It has no combinational path from the data or address inputs.

## Test plan
- **Reset, then single request.** Hold rst_n low: write_en = 0, both readies 0, data_a = rf_data_a for a non-zero address. Release rst_n, then drive req0 with addr 5'b01101 and data 64'h0000_0000_0000_aabb.
  - -> req0_ready = 1 in the same cycle.
  - -> Next cycle: write_en = 1, write_addr = 01101, write_data = ...aabb; with addr_a = 01101 and rf_data_a = 0, data_a = ...aabb.
- **Contention.** req0 (01101, ...aabb) and req1 (00100, 64'h0000_0000_e45f_b21f) both valid from reset.
  - -> Cycle 1: req0 is granted.
  - -> Cycle 2: req1 is granted.
  - -> write_addr sequence is 01101, then 00100.
  - -> With both held valid continuously, grants alternate every cycle.
- **Register 0.** req1 writes 64'hffff to addr 0.
  - -> req1_ready = 1.
  - -> write_en stays 0.
  - -> With addr_b = 0 and rf_data_b = 64'h1234, data_b = 0.
- **Bypass isolation.** A write is pending to 00100; addr_a = 00100, addr_b = 01101, rf_data_b = 64'haabb.
  - -> data_a = e45f_b21f (bypass).
  - -> data_b = aabb (no bypass).
- **Reset mid-write.** Pull rst_n low while write_en = 1.
  - -> write_en, write_addr and write_data go to 0 immediately, without a clock edge.
  - -> After release, requester 0 wins the first contention.
